// File: rtl/trng_word_responder_pkg.sv
// Shared types and defaults for the TRNG word responder.
package trng_pkg;

    localparam int unsigned WORD_W_DEF    = 32;
    localparam int unsigned REP_LIMIT_DEF = 16;

    // Von Neumann pair codes {first, second} that emit a bit.
    localparam logic [1:0] VN_PAIR_ZERO = 2'b01;
    localparam logic [1:0] VN_PAIR_ONE  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_VALID,
        ST_FAIL
    } state_e;

endpackage

// File: rtl/trng_word_responder_if.sv
// Request/ready handshake between the key loader (master) and the TRNG (slave).
interface trng_word_responder_if
    import trng_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF
);
    logic              trng_request;
    logic [WORD_W-1:0] random_number;
    logic              ready;
    logic              health_fail;

    modport master (output trng_request, input random_number, ready, health_fail);
    modport slave  (input trng_request, output random_number, ready, health_fail);
endinterface

// File: rtl/trng_word_responder_health_rct.sv
// Repetition-count health test: flags a run of REP_LIMIT identical bits.
module trng_health_rct
    import trng_pkg::*;
#(
    parameter int unsigned REP_LIMIT = REP_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic bit_in,
    output logic fail
);
    localparam int unsigned     CNT_W = $clog2(REP_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(REP_LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q, prev_d;

    // Next run length; fail trips on the same edge the run reaches the limit.
    always_comb begin
        cnt_d  = cnt_q;
        prev_d = prev_q;
        fail   = 1'b0;
        if (clear) begin
            cnt_d  = '0;
            prev_d = 1'b0;
        end else if (enable) begin
            prev_d = bit_in;
            if (cnt_q == '0 || bit_in != prev_q) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != LIMIT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            fail = (cnt_d == LIMIT);
        end
    end

    // Run-length state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
        end
    end
endmodule

// File: rtl/trng_word_responder.sv
// TRNG responder: synchronise, optionally debias, pack into words, hand out
// one word per four-phase request/ready transaction, with a sticky health fail.
module trng_word_responder
    import trng_pkg::*;
#(
    parameter int unsigned WORD_W      = WORD_W_DEF,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned REP_LIMIT   = REP_LIMIT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   raw_entropy_in,
    input  logic                   debias_en,
    trng_word_responder_if.slave   bus
);
    localparam int unsigned      CNT_W    = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    state_e            state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [WORD_W-1:0] random_number_q, random_number_d;
    logic              ready_q, ready_d;
    logic              health_fail_q, health_fail_d;
    logic              debias_q, debias_d;
    logic              pair_phase_q, pair_phase_d;
    logic              first_q, first_d;
    // Produced bit is registered and shifted in on the following edge.
    logic              bit_vld_q, bit_vld_d;
    logic              bit_val_q, bit_val_d;

    logic s;
    logic health_clear;
    logic health_en;
    logic health_trip;

    assign s = sync_q[SYNC_STAGES-1];

    assign bus.random_number = random_number_q;
    assign bus.ready         = ready_q;
    assign bus.health_fail   = health_fail_q;

    trng_health_rct #(
        .REP_LIMIT (REP_LIMIT)
    ) u_rct (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (health_clear),
        .enable (health_en),
        .bit_in (s),
        .fail   (health_trip)
    );

    // Next-state, bit production, packing and handshake outputs.
    always_comb begin
        state_d         = state_q;
        sync_d          = {sync_q[SYNC_STAGES-2:0], raw_entropy_in};
        bit_cnt_d       = bit_cnt_q;
        sh_d            = sh_q;
        random_number_d = random_number_q;
        ready_d         = ready_q;
        health_fail_d   = health_fail_q;
        debias_d        = debias_q;
        pair_phase_d    = pair_phase_q;
        first_d         = first_q;
        bit_vld_d       = 1'b0;
        bit_val_d       = bit_val_q;
        health_clear    = 1'b0;
        health_en       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.trng_request) begin
                    state_d      = ST_COLLECT;
                    bit_cnt_d    = '0;
                    sh_d         = '0;
                    pair_phase_d = 1'b0;
                    debias_d     = debias_en;
                    health_clear = 1'b1;
                end
            end
            ST_COLLECT: begin
                health_en = 1'b1;
                if (!debias_q) begin
                    bit_vld_d = 1'b1;
                    bit_val_d = s;
                end else if (!pair_phase_q) begin
                    first_d      = s;
                    pair_phase_d = 1'b1;
                end else begin
                    pair_phase_d = 1'b0;
                    if ({first_q, s} == VN_PAIR_ZERO) begin
                        bit_vld_d = 1'b1;
                        bit_val_d = 1'b0;
                    end else if ({first_q, s} == VN_PAIR_ONE) begin
                        bit_vld_d = 1'b1;
                        bit_val_d = 1'b1;
                    end
                end
                if (bit_vld_q) begin
                    sh_d      = {sh_q[WORD_W-2:0], bit_val_q};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
                if (health_trip) begin
                    health_fail_d = 1'b1;
                    ready_d       = 1'b0;
                    state_d       = ST_FAIL;
                end else if (!bus.trng_request) begin
                    state_d = ST_IDLE;
                end else if (bit_vld_q && bit_cnt_q == LAST_BIT) begin
                    random_number_d = sh_d;
                    ready_d         = 1'b1;
                    state_d         = ST_VALID;
                end
            end
            ST_VALID: begin
                if (!bus.trng_request) begin
                    ready_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_FAIL: begin
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            sync_q          <= '0;
            bit_cnt_q       <= '0;
            sh_q            <= '0;
            random_number_q <= '0;
            ready_q         <= 1'b0;
            health_fail_q   <= 1'b0;
            debias_q        <= 1'b0;
            pair_phase_q    <= 1'b0;
            first_q         <= 1'b0;
            bit_vld_q       <= 1'b0;
            bit_val_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            sync_q          <= sync_d;
            bit_cnt_q       <= bit_cnt_d;
            sh_q            <= sh_d;
            random_number_q <= random_number_d;
            ready_q         <= ready_d;
            health_fail_q   <= health_fail_d;
            debias_q        <= debias_d;
            pair_phase_q    <= pair_phase_d;
            first_q         <= first_d;
            bit_vld_q       <= bit_vld_d;
            bit_val_q       <= bit_val_d;
        end
    end
endmodule
